// File: rtl/fifo_pop_serializer.sv
// Pops DATA_LEN-bit words from a FIFO read port and streams them out LSB-first as OUT_LEN-bit valid/ready beats.
// Read-through: pop-to-valid 1 cycle, no bubble between words; registered: 2 cycles, one bubble; out_ready low holds the current beat.
module fifo_pop_serializer #(
    parameter int    DATA_LEN     = 64,
    parameter int    OUT_LEN      = 16,
    parameter string READ_THROUGH = "TRUE"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                fifo_empty,
    output logic                fifo_ren,
    input  logic [DATA_LEN-1:0] fifo_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OUT_LEN-1:0]  out_data,
    output logic                out_last,
    output logic                busy
);

    localparam int             BEATS    = DATA_LEN / OUT_LEN;
    localparam int             CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(BEATS - 1);
    localparam bit             RT       = (READ_THROUGH == "TRUE");

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND
    } state_t;

    state_t              state;
    logic [DATA_LEN-1:0] word_r;
    logic [CW-1:0]       cnt;

    logic xfer;
    logic last_beat;
    logic need_word;

    assign out_valid = (state == S_SEND);
    assign out_data  = word_r[OUT_LEN-1:0];
    assign last_beat = (cnt == LAST_CNT);
    assign out_last  = out_valid & last_beat;
    assign busy      = (state != S_IDLE);
    assign xfer      = out_valid & out_ready;

    // A new word is wanted when nothing is held, or when the last beat of the held word leaves this cycle.
    assign need_word = (state == S_IDLE) | (xfer & last_beat);
    assign fifo_ren  = ~rst & ~flush & ~fifo_empty & need_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            word_r <= '0;
            cnt    <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (fifo_ren) begin
                        if (RT) begin
                            word_r <= fifo_data;
                            cnt    <= '0;
                            state  <= S_SEND;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    word_r <= fifo_data;
                    cnt    <= '0;
                    state  <= S_SEND;
                end
                S_SEND: begin
                    if (xfer) begin
                        if (last_beat) begin
                            if (fifo_ren) begin
                                if (RT) begin
                                    word_r <= fifo_data;
                                    cnt    <= '0;
                                end else begin
                                    state <= S_FETCH;
                                end
                            end else begin
                                state <= S_IDLE;
                            end
                        end else begin
                            word_r <= word_r >> OUT_LEN;
                            cnt    <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_pop_serializer.sv
// Directed bench: read-through 64/16, registered 64/16 and 64/64 instances, each fed by a small FIFO model.
module tb_fifo_pop_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- instance A: 64/16 read-through ----------------
    logic        rst_a, empty_a, ren_a, flush_a, vld_a, rdy_a, last_a, busy_a;
    logic [63:0] data_a;
    logic [15:0] dat_a;
    logic [63:0] mem_a [64];
    logic [5:0]  wp_a, rp_a;
    assign empty_a = (wp_a == rp_a);
    assign data_a  = mem_a[rp_a];
    always @(posedge clk or posedge rst_a)
        if (rst_a) rp_a <= wp_a;
        else if (ren_a) rp_a <= rp_a + 6'd1;

    fifo_pop_serializer #(.DATA_LEN(64), .OUT_LEN(16), .READ_THROUGH("TRUE")) dut_a (
        .clk(clk), .rst(rst_a), .fifo_empty(empty_a), .fifo_ren(ren_a), .fifo_data(data_a),
        .flush(flush_a), .out_valid(vld_a), .out_ready(rdy_a), .out_data(dat_a),
        .out_last(last_a), .busy(busy_a));

    // ---------------- instance B: 64/16 registered ----------------
    logic        rst_b, empty_b, ren_b, flush_b, vld_b, rdy_b, last_b, busy_b;
    logic [63:0] rdata_b;
    logic [15:0] dat_b;
    logic [63:0] mem_b [64];
    logic [5:0]  wp_b, rp_b;
    assign empty_b = (wp_b == rp_b);
    always @(posedge clk or posedge rst_b)
        if (rst_b) begin
            rp_b    <= wp_b;
            rdata_b <= '0;
        end else if (ren_b) begin
            rp_b    <= rp_b + 6'd1;
            rdata_b <= mem_b[rp_b];
        end

    fifo_pop_serializer #(.DATA_LEN(64), .OUT_LEN(16), .READ_THROUGH("FALSE")) dut_b (
        .clk(clk), .rst(rst_b), .fifo_empty(empty_b), .fifo_ren(ren_b), .fifo_data(rdata_b),
        .flush(flush_b), .out_valid(vld_b), .out_ready(rdy_b), .out_data(dat_b),
        .out_last(last_b), .busy(busy_b));

    // ---------------- instance C: 64/64 read-through ----------------
    logic        rst_c, empty_c, ren_c, flush_c, vld_c, rdy_c, last_c, busy_c;
    logic [63:0] data_c, dat_c;
    logic [63:0] mem_c [64];
    logic [5:0]  wp_c, rp_c;
    assign empty_c = (wp_c == rp_c);
    assign data_c  = mem_c[rp_c];
    always @(posedge clk or posedge rst_c)
        if (rst_c) rp_c <= wp_c;
        else if (ren_c) rp_c <= rp_c + 6'd1;

    fifo_pop_serializer #(.DATA_LEN(64), .OUT_LEN(64), .READ_THROUGH("TRUE")) dut_c (
        .clk(clk), .rst(rst_c), .fifo_empty(empty_c), .fifo_ren(ren_c), .fifo_data(data_c),
        .flush(flush_c), .out_valid(vld_c), .out_ready(rdy_c), .out_data(dat_c),
        .out_last(last_c), .busy(busy_c));

    // ---------------- helpers ----------------
    task automatic push_a(input logic [63:0] w);
        mem_a[wp_a] = w;
        wp_a = wp_a + 6'd1;
    endtask
    task automatic push_b(input logic [63:0] w);
        mem_b[wp_b] = w;
        wp_b = wp_b + 6'd1;
    endtask
    task automatic push_c(input logic [63:0] w);
        mem_c[wp_c] = w;
        wp_c = wp_c + 6'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit          push;
        logic [63:0] word;
        bit          rdy;
        bit          fl;
        bit          e_ren;
        bit          e_vld;
        logic [15:0] e_dat;
        bit          e_last;
        bit          e_busy;
    } vec_t;
    vec_t vec[$];

    function automatic void add(input bit push, input logic [63:0] word, input bit rdy, input bit fl,
                                input bit e_ren, input bit e_vld, input logic [15:0] e_dat,
                                input bit e_last, input bit e_busy);
        vec_t v;
        v.push = push; v.word = word; v.rdy = rdy; v.fl = fl;
        v.e_ren = e_ren; v.e_vld = e_vld; v.e_dat = e_dat; v.e_last = e_last; v.e_busy = e_busy;
        vec.push_back(v);
    endfunction

    localparam logic [63:0] W1 = 64'h4444_3333_2222_1111;
    localparam logic [63:0] X1 = 64'hA004_A003_A002_A001;
    localparam logic [63:0] X2 = 64'hB004_B003_B002_B001;
    localparam logic [63:0] X3 = 64'hC004_C003_C002_C001;
    localparam logic [63:0] YW = 64'hD004_D003_D002_D001;
    localparam logic [63:0] ZW = 64'hE004_E003_E002_E001;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] exp_q[$];
        logic [63:0] rw;
        logic [63:0] wds [3];
        logic [15:0] pd;
        logic        pl, pstall;
        int          rx, viol_ren, viol_stab, cyc;

        rst_a = 1; rst_b = 1; rst_c = 1;
        flush_a = 0; flush_b = 0; flush_c = 0;
        rdy_a = 0; rdy_b = 1; rdy_c = 1;
        wp_a = 0; wp_b = 0; wp_c = 0;

        // --- reset: all outputs zero, no pop even with data present ---
        @(negedge clk);
        push_a(64'h0123_4567_89AB_CDEF);
        #1;
        chk("rst ren",  ren_a,  0);
        chk("rst vld",  vld_a,  0);
        chk("rst data", dat_a,  0);
        chk("rst last", last_a, 0);
        chk("rst busy", busy_a, 0);
        @(negedge clk);
        rst_a = 0; rst_b = 0; rst_c = 0;

        // --- table: basic, back-to-back, empty at reload, flush, stall ---
        //   push word  rdy fl  ren vld data     last busy
        add(1, W1, 1, 0,  1, 0, 16'h0,    0, 0);
        add(0, 0,  1, 0,  0, 1, 16'h1111, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'h2222, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'h3333, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'h4444, 1, 1);
        add(1, X1, 1, 0,  1, 0, 16'h0,    0, 0);
        add(1, X2, 1, 0,  0, 1, 16'hA001, 0, 1);
        add(1, X3, 1, 0,  0, 1, 16'hA002, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hA003, 0, 1);
        add(0, 0,  1, 0,  1, 1, 16'hA004, 1, 1);
        add(0, 0,  1, 0,  0, 1, 16'hB001, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hB002, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hB003, 0, 1);
        add(0, 0,  1, 0,  1, 1, 16'hB004, 1, 1);
        add(0, 0,  1, 0,  0, 1, 16'hC001, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hC002, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hC003, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hC004, 1, 1);
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 0,  0, 0, 16'h0, 0, 0);
        add(1, YW, 1, 0,  1, 0, 16'h0,    0, 0);
        add(1, ZW, 1, 0,  0, 1, 16'hD001, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hD002, 0, 1);
        add(0, 0,  1, 1,  0, 1, 16'hD003, 0, 1);
        add(0, 0,  1, 0,  1, 0, 16'h0,    0, 0);
        add(0, 0,  1, 0,  0, 1, 16'hE001, 0, 1);
        add(0, 0,  0, 0,  0, 1, 16'hE002, 0, 1);
        add(0, 0,  0, 0,  0, 1, 16'hE002, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hE002, 0, 1);
        add(0, 0,  0, 0,  0, 1, 16'hE003, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hE003, 0, 1);
        add(0, 0,  1, 0,  0, 1, 16'hE004, 1, 1);
        add(0, 0,  1, 0,  0, 0, 16'h0,    0, 0);

        foreach (vec[i]) begin
            @(negedge clk);
            if (vec[i].push) push_a(vec[i].word);
            rdy_a   = vec[i].rdy;
            flush_a = vec[i].fl;
            #1;
            chk($sformatf("vec%0d ren", i),  ren_a,  vec[i].e_ren);
            chk($sformatf("vec%0d vld", i),  vld_a,  vec[i].e_vld);
            chk($sformatf("vec%0d last", i), last_a, vec[i].e_last);
            chk($sformatf("vec%0d busy", i), busy_a, vec[i].e_busy);
            if (vec[i].e_vld) chk($sformatf("vec%0d data", i), dat_a, vec[i].e_dat);
        end
        flush_a = 0;

        // --- A: random backpressure, scoreboard on beats ---
        @(negedge clk);
        for (int k = 0; k < 6; k++) begin
            rw = {$urandom, $urandom};
            push_a(rw);
            for (int b = 0; b < 4; b++) exp_q.push_back(rw >> (16 * b));
        end
        rx = 0; viol_ren = 0; viol_stab = 0; pstall = 0; pd = 0; pl = 0; cyc = 0;
        while (exp_q.size() > 0 && cyc < 400) begin
            if (cyc > 0) @(negedge clk);
            rdy_a = ($urandom_range(0, 9) >= 3);
            #1;
            if (ren_a && empty_a) viol_ren++;
            if (pstall && (!vld_a || dat_a !== pd || last_a !== pl)) viol_stab++;
            if (vld_a && rdy_a) begin
                rw = exp_q.pop_front();
                chk($sformatf("bp beat%0d data", rx), dat_a, rw[15:0]);
                chk($sformatf("bp beat%0d last", rx), last_a, (rx % 4) == 3);
                rx++;
            end
            pstall = vld_a & ~rdy_a;
            pd = dat_a;
            pl = last_a;
            cyc++;
        end
        chk("bp beats received", rx, 24);
        chk("bp ren while empty", viol_ren, 0);
        chk("bp stall stability", viol_stab, 0);
        rdy_a = 1;

        // --- B: registered mode, three words back-to-back ---
        wds[0] = 64'h1004_1003_1002_1001;
        wds[1] = 64'h2004_2003_2002_2001;
        wds[2] = 64'h3004_3003_3002_3001;
        for (int c = 0; c < 18; c++) begin
            int  beat;
            bit  ev;
            @(negedge clk);
            if (c == 0) for (int k = 0; k < 3; k++) push_b(wds[k]);
            #1;
            ev   = (c >= 2 && c <= 15 && ((c - 2) % 5) != 4);
            beat = (c - 2) % 5;
            chk($sformatf("reg c%0d ren", c),  ren_b,  (c == 0 || c == 5 || c == 10));
            chk($sformatf("reg c%0d vld", c),  vld_b,  ev);
            chk($sformatf("reg c%0d busy", c), busy_b, (c >= 1 && c <= 15));
            if (ev) begin
                rw = wds[(c - 2) / 5] >> (16 * beat);
                chk($sformatf("reg c%0d data", c), dat_b, rw[15:0]);
                chk($sformatf("reg c%0d last", c), last_b, beat == 3);
            end
        end

        // --- B: flush in FETCH drops the popped word; next word has 2-cycle latency ---
        @(negedge clk);
        push_b(64'h5555_5555_5555_5555);
        push_b(64'h6004_6003_6002_6001);
        #1;
        chk("fetchfl pop", ren_b, 1);
        @(negedge clk);
        flush_b = 1;
        #1;
        chk("fetchfl ren",  ren_b,  0);
        chk("fetchfl busy", busy_b, 1);
        chk("fetchfl vld",  vld_b,  0);
        @(negedge clk);
        flush_b = 0;
        #1;
        chk("fetchfl idle busy", busy_b, 0);
        chk("fetchfl next pop",  ren_b,  1);
        @(negedge clk);
        #1;
        chk("fetchfl fetch vld", vld_b, 0);
        chk("fetchfl fetch ren", ren_b, 0);
        @(negedge clk);
        #1;
        chk("fetchfl out vld",  vld_b, 1);
        chk("fetchfl out data", dat_b, 16'h6001);

        // --- C: 64/64, every beat last; flush on last beat blocks the pop ---
        @(negedge clk);
        push_c(64'hAAAA_0000_0000_0001);
        push_c(64'hBBBB_0000_0000_0002);
        #1;
        chk("w64 pop0", ren_c, 1);
        chk("w64 vld0", vld_c, 0);
        @(negedge clk);
        #1;
        chk("w64 vld1",  vld_c,  1);
        chk("w64 last1", last_c, 1);
        chk("w64 data1", dat_c,  64'hAAAA_0000_0000_0001);
        chk("w64 pop1",  ren_c,  1);
        @(negedge clk);
        push_c(64'hCCCC_0000_0000_0003);
        flush_c = 1;
        #1;
        chk("w64 data2",  dat_c,  64'hBBBB_0000_0000_0002);
        chk("w64 last2",  last_c, 1);
        chk("w64 fl ren", ren_c,  0);
        @(negedge clk);
        flush_c = 0;
        #1;
        chk("w64 fl vld",  vld_c, 0);
        chk("w64 fl busy", busy_c, 0);
        chk("w64 pop3",    ren_c, 1);
        @(negedge clk);
        #1;
        chk("w64 data4", dat_c,  64'hCCCC_0000_0000_0003);
        chk("w64 last4", last_c, 1);

        // --- C: asynchronous reset mid-word, checked before the next clock edge ---
        #2;
        rst_c = 1;
        #1;
        chk("arst vld",  vld_c,  0);
        chk("arst last", last_c, 0);
        chk("arst data", dat_c,  0);
        chk("arst busy", busy_c, 0);
        chk("arst ren",  ren_c,  0);
        @(negedge clk);
        rst_c = 0;
        @(negedge clk);
        #1;
        chk("arst idle busy", busy_c, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_pop_serializer.md
# fifo_pop_serializer

Read-side consumer for the team's FIFOs: pops DATA_LEN-bit words through a FIFO read port (empty/ren/data) and emits each word as DATA_LEN/OUT_LEN narrower beats on a valid/ready stream, LSB beat first. It sits in the read clock domain, downstream of a FIFO's read port and upstream of narrow peripherals such as UART/SPI transmit paths or debug links. It supports FIFOs with read-through (same-cycle) and registered (next-cycle) read data.

## Interface
- DATA_LEN, 64, FIFO word width; must be an integer multiple of OUT_LEN.
- OUT_LEN, 16, output beat width; BEATS = DATA_LEN/OUT_LEN, BEATS ≥ 1.
- READ_THROUGH, "TRUE", "TRUE": fifo_data is valid in the same cycle as !fifo_empty; any other value: fifo_data is valid the cycle after fifo_ren.
- clk  input  1  the single clock.
- rst  input  1  reset: asynchronous, active-high.
- fifo_empty  input  1  FIFO empty flag.
- fifo_ren  output  1  pop request; combinational; never asserted while fifo_empty=1 or rst=1.
- fifo_data  input  DATA_LEN  FIFO read data.
- flush  input  1  synchronous discard of the held word; returns to IDLE.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accept.
- out_data  output  OUT_LEN  current beat.
- out_last  output  1  current beat is the final beat of its word.
- busy  output  1  state ≠ IDLE.

## Operation
- States: IDLE (no word held), FETCH (registered mode only; pop issued, data arrives this cycle), SEND (word held, beats presented).
- Storage: word_r (DATA_LEN shift register), beat counter cnt (width clog2(BEATS), min 1 bit).
- out_data = word_r[OUT_LEN-1:0]; out_valid = (state==SEND); out_last = out_valid & (cnt==BEATS-1).
- Handshake: beat transfers when out_valid & out_ready. On transfer, if not last, word_r shifts right by OUT_LEN and cnt increments.
- out_data and out_last must stay stable while out_valid=1 and out_ready=0. out_valid never drops without a transfer, except on flush or rst.
- A word is needed in IDLE, and on the last-beat transfer in SEND ("reload").
- READ_THROUGH="TRUE":
  - fifo_ren = !fifo_empty & (IDLE | reload).
  - When fifo_ren fires, word_r loads fifo_data, cnt=0, next state SEND.
  - Reload with fifo_empty=1 goes to IDLE.
- Registered mode:
  - fifo_ren fires under the same condition, and the next state is FETCH.
  - In FETCH, word_r loads fifo_data, cnt=0, next state SEND.
  - FETCH never issues fifo_ren.
- flush (highest priority after rst):
  - Next state IDLE, cnt=0, and fifo_ren=0 that cycle.
  - A beat transfer coinciding with flush still counts as accepted downstream, but the rest of the word is dropped.
  - A flush in FETCH discards the already-popped word.
- BEATS=1: every transfer is last; out_last=out_valid.

## Timing
- Reset values: state IDLE, word_r 0, cnt 0, out_valid 0, out_last 0, out_data 0, busy 0, fifo_ren 0.
- Reset deasserting mid-word simply restarts from IDLE. Words already popped are lost; the FIFO is reset with it.
- Read-through latency: fifo_empty falls in cycle t → fifo_ren=1 in t → out_valid=1 in t+1.
- Read-through throughput: back-to-back words with no bubble, i.e. BEATS beats per BEATS cycles when out_ready=1 and the FIFO is non-empty.
- Registered latency: fifo_ren in t → FETCH in t+1 → out_valid in t+2.
- Registered throughput: one idle cycle between words (BEATS beats per BEATS+1 cycles).
- FIFO going empty mid-word has no effect until reload.
- fifo_empty rising in the reload cycle → IDLE, out_valid=0 in the next cycle.

## Test plan
- Reset and basic (DATA_LEN=64, OUT_LEN=16, read-through): hold rst=1 → all outputs 0. Push 0x4444_3333_2222_1111 with out_ready=1 → beats 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles; out_last only on 0x4444; exactly one fifo_ren pulse.
- Back-to-back: 3 words queued, out_ready=1 → 12 consecutive valid cycles, fifo_ren on cycles 0, 4 and 8, no gap. Registered mode → 15 cycles with a 1-cycle gap after each word.
- Backpressure: out_ready random 30% → out_data/out_last stable while stalled; beat sequence and counts exact; fifo_ren never asserted while fifo_empty=1.
- Empty at reload: single word then FIFO empty → IDLE after 4th beat, busy=0, fifo_ren=0. Push again 5 cycles later → 1-cycle (read-through) or 2-cycle (registered) latency to out_valid.
- Flush: flush during beat 2 of word A with word B queued → out_valid=0 next cycle. Next output is word B beat 0. Registered mode, flush in FETCH → popped word dropped, fifo_ren=0 that cycle.
- Edge config (OUT_LEN=DATA_LEN=64): every beat has out_last=1. Async rst asserted mid-word → outputs 0 immediately without a clock edge.
